// File: rtl/load_store_unit_if.sv
// Bundle of the pipeline request/response handshake and the data memory port
// of the load/store unit.
//   master : the load/store unit (accepts pipeline requests, initiates memory
//            transactions, returns responses)
//   slave  : the environment (pipeline MEM stage plus data memory)
// Signals: req_valid/req_ready/alucode/addr/wdata (request), resp_valid/
// resp_data/resp_err (response), mem_req/mem_we/mem_addr/mem_be/mem_wdata/
// mem_rdata/mem_ack (word-organised memory port).
interface load_store_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [5:0]        alucode;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              resp_valid;
  logic [31:0]       resp_data;
  logic              resp_err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    input  req_valid, alucode, addr, wdata, mem_rdata, mem_ack,
    output req_ready, resp_valid, resp_data, resp_err,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    output req_valid, alucode, addr, wdata, mem_rdata, mem_ack,
    input  req_ready, resp_valid, resp_data, resp_err,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: CPU-side initiator for the word-organised data memory.
// Accepts one load/store per handshake, generates byte enables and lane-shifted
// store data, splits accesses that straddle a word boundary into two word
// transactions, and returns sign/zero-extended load data.
// Ports:
//   clk  - clock, all state changes on posedge
//   rst  - synchronous reset, active-high
//   bus  - load_store_unit_if.master: pipeline request/response handshake and
//          data memory port (mem_addr is a word address, mem_be per byte lane)
// Alucode values (shared with the pipeline decoder):
//   ADD=0, LB=20, LH=21, LW=22, LBU=23, LHU=24, SB=25, SH=26, SW=27
module load_store_unit #(
  parameter int unsigned ADDR_W = 32
) (
  input logic               clk,
  input logic               rst,
  load_store_unit_if.master bus
);

  localparam logic [5:0] ALU_LB  = 6'd20;
  localparam logic [5:0] ALU_LH  = 6'd21;
  localparam logic [5:0] ALU_LW  = 6'd22;
  localparam logic [5:0] ALU_LBU = 6'd23;
  localparam logic [5:0] ALU_LHU = 6'd24;
  localparam logic [5:0] ALU_SB  = 6'd25;
  localparam logic [5:0] ALU_SH  = 6'd26;
  localparam logic [5:0] ALU_SW  = 6'd27;

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  state_t state_q, state_d;

  // Latched request attributes
  logic [1:0]        off_q;
  size_t             sz_q;
  logic              sgn_q;
  logic              load_q;
  logic [3:0]        hi_be_q;
  logic [31:0]       hi_wdata_q;
  logic [31:0]       r0_q;

  // Registered outputs
  logic [31:0]       resp_data_q;
  logic              resp_err_q;
  logic              mem_we_q;
  logic [ADDR_W-3:0] mem_addr_q;
  logic [3:0]        mem_be_q;
  logic [31:0]       mem_wdata_q;

  // Request decode
  logic              dec_mem;
  logic              dec_load;
  logic              dec_sgn;
  size_t             dec_sz;
  logic [7:0]        mask8;
  logic [63:0]       w64;

  logic              accept;
  logic              acc0_done;
  logic              acc1_done;

  function automatic logic [3:0] size_lanes(input size_t sz);
    case (sz)
      SZ_B:    return 4'b0001;
      SZ_H:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_bits(input logic [3:0] lanes);
    return {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
  endfunction

  // pair holds {upper word, lower word}; the requested bytes start at lane off.
  function automatic logic [31:0] extend(input logic [63:0] pair, input logic [1:0] off,
                                         input size_t sz, input logic sgn);
    logic [63:0] x;
    x = pair >> {off, 3'b000};
    case (sz)
      SZ_B:    return {{24{sgn & x[7]}}, x[7:0]};
      SZ_H:    return {{16{sgn & x[15]}}, x[15:0]};
      default: return x[31:0];
    endcase
  endfunction

  always_comb begin
    dec_mem  = 1'b1;
    dec_load = 1'b1;
    dec_sgn  = 1'b0;
    dec_sz   = SZ_W;
    case (bus.alucode)
      ALU_LB:  begin dec_sz = SZ_B; dec_sgn = 1'b1; end
      ALU_LBU: dec_sz = SZ_B;
      ALU_LH:  begin dec_sz = SZ_H; dec_sgn = 1'b1; end
      ALU_LHU: dec_sz = SZ_H;
      ALU_LW:  dec_sz = SZ_W;
      ALU_SB:  begin dec_sz = SZ_B; dec_load = 1'b0; end
      ALU_SH:  begin dec_sz = SZ_H; dec_load = 1'b0; end
      ALU_SW:  begin dec_sz = SZ_W; dec_load = 1'b0; end
      default: begin dec_mem = 1'b0; dec_load = 1'b0; end
    endcase
  end

  // Byte mask and store data over an 8-byte window spanning the addressed word
  // and the next one; the upper half is non-zero only for straddling accesses.
  always_comb begin
    mask8 = {4'b0000, size_lanes(dec_sz)} << bus.addr[1:0];
    w64   = {32'b0, bus.wdata & lane_bits(size_lanes(dec_sz))} << {bus.addr[1:0], 3'b000};
  end

  assign accept    = (state_q == IDLE) && bus.req_valid;
  assign acc0_done = (state_q == ACC0) && bus.mem_ack && (hi_be_q == 4'b0000);
  assign acc1_done = (state_q == ACC1) && bus.mem_ack;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d = dec_mem ? ACC0 : RESP;
        end
      end
      ACC0: begin
        if (bus.mem_ack) begin
          state_d = (hi_be_q != 4'b0000) ? ACC1 : RESP;
        end
      end
      ACC1: begin
        if (bus.mem_ack) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    bus.req_ready  = 1'b0;
    bus.mem_req    = 1'b0;
    bus.resp_valid = 1'b0;
    case (state_q)
      IDLE:    bus.req_ready  = 1'b1;
      ACC0:    bus.mem_req    = 1'b1;
      ACC1:    bus.mem_req    = 1'b1;
      RESP:    bus.resp_valid = 1'b1;
      default: bus.req_ready  = 1'b0;
    endcase
  end

  // Datapath: memory port registers, read capture and response formation.
  // The response word is formed on the edge that completes the last memory
  // transaction, combining the live mem_rdata with the earlier captured word.
  always_ff @(posedge clk) begin
    if (rst) begin
      off_q       <= '0;
      sz_q        <= SZ_W;
      sgn_q       <= 1'b0;
      load_q      <= 1'b0;
      hi_be_q     <= '0;
      hi_wdata_q  <= '0;
      r0_q        <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      if (accept) begin
        off_q  <= bus.addr[1:0];
        sz_q   <= dec_sz;
        sgn_q  <= dec_sgn;
        load_q <= dec_load;
        if (dec_mem) begin
          hi_be_q     <= mask8[7:4];
          hi_wdata_q  <= w64[63:32];
          mem_we_q    <= ~dec_load;
          mem_addr_q  <= bus.addr[ADDR_W-1:2];
          mem_be_q    <= mask8[3:0];
          mem_wdata_q <= w64[31:0];
        end else begin
          resp_data_q <= '0;
          resp_err_q  <= 1'b1;
        end
      end

      if ((state_q == ACC0) && bus.mem_ack) begin
        r0_q <= bus.mem_rdata;
        if (hi_be_q != 4'b0000) begin
          // Second word wraps naturally at the top of the word address space.
          mem_addr_q  <= mem_addr_q + {{(ADDR_W-3){1'b0}}, 1'b1};
          mem_be_q    <= hi_be_q;
          mem_wdata_q <= hi_wdata_q;
        end
      end

      if (acc0_done) begin
        resp_err_q  <= 1'b0;
        resp_data_q <= load_q ? extend({32'b0, bus.mem_rdata}, off_q, sz_q, sgn_q) : '0;
      end

      if (acc1_done) begin
        resp_err_q  <= 1'b0;
        resp_data_q <= load_q ? extend({bus.mem_rdata, r0_q}, off_q, sz_q, sgn_q) : '0;
      end
    end
  end

  assign bus.resp_data = resp_data_q;
  assign bus.resp_err  = resp_err_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule
